// File: rtl/alu_share_arb.sv
// alu_share_arb: two-requester arbiter/sequencer time-sharing one 32-bit ALU
// Ports: CLK, RST (sync, active-high); req_valid/req_ready handshake with packed
//        per-requester operands req_srcA/req_srcB (32b each) and req_fun (4b each);
//        rsp_valid/rsp_ready handshake per requester with shared rsp_result,
//        rsp_zero, rsp_err; busy high whenever an operation is in flight.
module alu_share_arb #(
    parameter int FIXED_PRIO = 0,
    parameter int W = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_srcA,
    input  logic [2*W-1:0] req_srcB,
    input  logic [7:0]     req_fun,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t       state_q;
    logic         owner_q;
    logic         last_q;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic [3:0]   fun_q;
    logic [W-1:0] result_q;
    logic         zero_q;
    logic         err_q;
    logic         gnt;
    logic [W-1:0] alu_res;
    logic         alu_err;
    logic [4:0]   shamt;
    // Tie goes to the requester that did not win last time (or always to 0 in fixed mode).
    assign gnt = (&req_valid) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : req_valid[1];
    // Handshake outputs are masked during reset so a dropped operation is never visible.
    assign req_ready = (state_q == IDLE && !RST && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == RESP && !RST) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy = state_q != IDLE;
    assign rsp_result = result_q;
    assign rsp_zero = zero_q;
    assign rsp_err = err_q;
    assign shamt = opb_q[4:0];
    always_comb begin
        alu_err = 1'b0;
        case (fun_q)
            4'b0000: alu_res = opa_q + opb_q;
            4'b1000: alu_res = opa_q - opb_q;
            4'b0110: alu_res = opa_q | opb_q;
            4'b0111: alu_res = opa_q & opb_q;
            4'b0100: alu_res = opa_q ^ opb_q;
            4'b0101: alu_res = opa_q >> shamt;
            4'b0001: alu_res = opa_q << shamt;
            4'b1101: alu_res = $signed(opa_q) >>> shamt;
            4'b0010: alu_res = {{(W-1){1'b0}}, $signed(opa_q) < $signed(opb_q)};
            4'b0011: alu_res = {{(W-1){1'b0}}, opa_q < opb_q};
            4'b1001: alu_res = opa_q;
            default: begin
                alu_res = W'(32'hDEADBEEF);
                alu_err = 1'b1;
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|req_ready) begin
                    opa_q   <= gnt ? req_srcA[2*W-1:W] : req_srcA[W-1:0];
                    opb_q   <= gnt ? req_srcB[2*W-1:W] : req_srcB[W-1:0];
                    fun_q   <= gnt ? req_fun[7:4] : req_fun[3:0];
                    owner_q <= gnt;
                    last_q  <= gnt;
                    state_q <= EXEC;
                end
                EXEC: begin
                    result_q <= alu_res;
                    zero_q   <= alu_res == '0;
                    err_q    <= alu_err;
                    state_q  <= RESP;
                end
                RESP: if (rsp_ready[owner_q]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: scoreboard bench for the shared-ALU arbiter (round-robin and fixed-priority builds)
module tb_alu_share_arb;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] r;
        logic        z;
        logic        e;
    } op_t;
    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  pend = 2'b00;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  f [2];
    logic [33:0] exp_r [2];
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_srcA;
    logic [63:0] req_srcB;
    logic [7:0]  req_fun;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  fp_valid = 2'b00;
    logic [1:0]  fp_ready;
    logic [63:0] fp_a = {32'd2, 32'd1};
    logic [63:0] fp_b = {32'd20, 32'd10};
    logic [7:0]  fp_fun = 8'h00;
    logic [1:0]  fp_rsp_valid;
    logic [1:0]  fp_rsp_ready = 2'b11;
    logic [31:0] fp_result;
    logic        fp_zero;
    logic        fp_err;
    logic        fp_busy;
    logic [35:0] exp_q [$];
    logic [35:0] obs_q [$];
    int          acc_log [$];
    int          inflight = 0;
    int          total = 0;
    int          bad = 0;
    logic        timed_out;
    op_t         tbl [11];

    assign req_valid = pend;
    assign req_srcA = {a[1], a[0]};
    assign req_srcB = {b[1], b[0]};
    assign req_fun = {f[1], f[0]};

    always #5 clk = ~clk;

    alu_share_arb #(.FIXED_PRIO(0), .W(32)) u_dut (
        .CLK(clk), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_srcA(req_srcA), .req_srcB(req_srcB), .req_fun(req_fun),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    alu_share_arb #(.FIXED_PRIO(1), .W(32)) u_fp (
        .CLK(clk), .RST(RST),
        .req_valid(fp_valid), .req_ready(fp_ready),
        .req_srcA(fp_a), .req_srcB(fp_b), .req_fun(fp_fun),
        .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
        .rsp_result(fp_result), .rsp_zero(fp_zero), .rsp_err(fp_err),
        .busy(fp_busy)
    );

    task automatic load(input int i, input logic [31:0] a_, input logic [31:0] b_,
                        input logic [3:0] f_, input logic [33:0] e_);
        pend[i] = 1'b1;
        a[i] = a_;
        b[i] = b_;
        f[i] = f_;
        exp_r[i] = e_;
    endtask

    // Called at a falling edge: records handshakes, advances one cycle, returns at the next falling edge.
    task automatic tick();
        logic [1:0] acc;
        #1;
        acc = req_valid & req_ready;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                exp_q.push_back({2'b01 << i, exp_r[i]});
                acc_log.push_back(i);
                inflight++;
            end
        end
        if ((rsp_valid & rsp_ready) != 2'b00) begin
            obs_q.push_back({rsp_valid, rsp_result, rsp_zero, rsp_err});
            inflight--;
        end
        @(posedge clk);
        #1;
        pend = pend & ~acc;
        @(negedge clk);
    endtask

    task automatic run(input int maxc);
        int c;
        c = 0;
        while ((pend != 2'b00 || inflight != 0) && c < maxc) begin
            tick();
            c++;
        end
        timed_out = (pend != 2'b00 || inflight != 0);
    endtask

    task automatic test_reset();
        logic [35:0] o, e;
        RST = 1'b1;
        rsp_ready = 2'b11;
        load(0, 32'd1, 32'd2, 4'b0000, {32'd3, 1'b0, 1'b0});
        load(1, 32'd10, 32'd20, 4'b0000, {32'd30, 1'b0, 1'b0});
        repeat (2) begin
            @(negedge clk);
            total++;
            if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
            total++;
            if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
            total++;
            if ({rsp_result, rsp_zero, rsp_err} !== 34'd0) begin
                bad++; $display("FAIL reset_rsp got=%h/%b/%b exp=0/0/0", rsp_result, rsp_zero, rsp_err);
            end
        end
        RST = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b exp=01", req_ready); end
        run(20);
        total++;
        if (timed_out) begin bad++; $display("FAIL reset_timeout got=pending exp=drained"); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_rsp_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL reset_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_single();
        logic [35:0] o, e;
        rsp_ready = 2'b11;
        load(1, 32'd5, 32'd7, 4'b1000, {32'hFFFFFFFE, 1'b0, 1'b0});
        #1;
        total++;
        if (req_ready !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", req_ready); end
        tick();
        total++;
        if (rsp_valid !== 2'b00 || busy !== 1'b1) begin
            bad++; $display("FAIL single_n1 got=valid %b busy %b exp=valid 00 busy 1", rsp_valid, busy);
        end
        tick();
        total++;
        if (rsp_valid !== 2'b10) begin bad++; $display("FAIL single_n2_valid got=%b exp=10", rsp_valid); end
        total++;
        if ({rsp_result, rsp_zero, rsp_err} !== {32'hFFFFFFFE, 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_n2_rsp got=%h/%b/%b exp=fffffffe/0/0", rsp_result, rsp_zero, rsp_err);
        end
        tick();
        total++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            bad++; $display("FAIL single_n3 got=busy %b valid %b exp=busy 0 valid 00", busy, rsp_valid);
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL single_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        logic [35:0] o, e;
        logic [31:0] x, y, s;
        int sent [2];
        int c;
        sent = '{0, 0};
        c = 0;
        rsp_ready = 2'b11;
        acc_log.delete();
        while ((sent[0] < 4 || sent[1] < 4 || pend != 2'b00 || inflight != 0) && c < 100) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && sent[i] < 4) begin
                    x = $urandom;
                    y = $urandom;
                    s = x + y;
                    load(i, x, y, 4'b0000, {s, s == 32'd0, 1'b0});
                    sent[i]++;
                end
            end
            tick();
            c++;
        end
        total++;
        if (acc_log.size() != 8) begin bad++; $display("FAIL rr_count got=%0d exp=8", acc_log.size()); end
        for (int k = 0; k < acc_log.size(); k++) begin
            total++;
            if (acc_log[k] != k % 2) begin bad++; $display("FAIL rr_grant%0d got=%0d exp=%0d", k, acc_log[k], k % 2); end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL rr_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rr_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [35:0] o, e;
        int c;
        c = 0;
        rsp_ready = 2'b00;
        load(0, 32'd100, 32'd23, 4'b0000, {32'd123, 1'b0, 1'b0});
        load(1, 32'd7, 32'd8, 4'b0000, {32'd15, 1'b0, 1'b0});
        while (rsp_valid == 2'b00 && c < 10) begin
            tick();
            c++;
        end
        total++;
        if (rsp_valid !== 2'b01) begin bad++; $display("FAIL bp_first got=%b exp=01", rsp_valid); end
        repeat (5) begin
            tick();
            total++;
            if (rsp_valid !== 2'b01 || req_ready !== 2'b00 || rsp_result !== 32'd123) begin
                bad++; $display("FAIL bp_hold got=valid %b ready %b res %h exp=valid 01 ready 00 res 7b",
                                rsp_valid, req_ready, rsp_result);
            end
        end
        rsp_ready = 2'b11;
        tick();
        total++;
        if (busy !== 1'b0 || req_ready !== 2'b10) begin
            bad++; $display("FAIL bp_release got=busy %b ready %b exp=busy 0 ready 10", busy, req_ready);
        end
        run(20);
        total++;
        if (timed_out) begin bad++; $display("FAIL bp_timeout got=pending exp=drained"); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL bp_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bp_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_opcodes();
        logic [35:0] o, e;
        rsp_ready = 2'b11;
        tbl = '{
            {32'h80000000, 32'h00000021, 4'b1101, 32'hC0000000, 1'b0, 1'b0},
            {32'h00000001, 32'hFFFFFFFF, 4'b0011, 32'h00000001, 1'b0, 1'b0},
            {32'h00000001, 32'hFFFFFFFF, 4'b0010, 32'h00000000, 1'b1, 1'b0},
            {32'h00000003, 32'h00000004, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1},
            {32'hFFFFFFFF, 32'h00000001, 4'b0000, 32'h00000000, 1'b1, 1'b0},
            {32'h000000F0, 32'h0000000F, 4'b0110, 32'h000000FF, 1'b0, 1'b0},
            {32'h00000001, 32'h00000004, 4'b0001, 32'h00000010, 1'b0, 1'b0},
            {32'h12345678, 32'h0000FFFF, 4'b1001, 32'h12345678, 1'b0, 1'b0},
            {32'h80000000, 32'h0000001F, 4'b0101, 32'h00000001, 1'b0, 1'b0},
            {32'h000000FF, 32'h0000000F, 4'b0100, 32'h000000F0, 1'b0, 1'b0},
            {32'h000000FF, 32'h0000000F, 4'b0111, 32'h0000000F, 1'b0, 1'b0}
        };
        for (int k = 0; k < 11; k++) begin
            load(k % 2, tbl[k].a, tbl[k].b, tbl[k].f, {tbl[k].r, tbl[k].z, tbl[k].e});
            run(10);
            total++;
            if (timed_out) begin bad++; $display("FAIL op%0d_timeout got=pending exp=drained", k); end
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL op_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL op_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [35:0] o, e;
        rsp_ready = 2'b11;
        load(0, 32'd3, 32'd4, 4'b0000, {32'd7, 1'b0, 1'b0});
        tick();
        total++;
        if (busy !== 1'b1 || rsp_valid !== 2'b00) begin
            bad++; $display("FAIL rmid_exec got=busy %b valid %b exp=busy 1 valid 00", busy, rsp_valid);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
        inflight = 0;
        repeat (4) begin
            tick();
            total++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
                bad++; $display("FAIL rmid_exec_drop got=valid %b busy %b exp=valid 00 busy 0", rsp_valid, busy);
            end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_exec_obs got=%0d exp=0", obs_q.size()); end
        rsp_ready = 2'b00;
        load(1, 32'd9, 32'd9, 4'b1000, {32'd0, 1'b1, 1'b0});
        tick();
        tick();
        total++;
        if (rsp_valid !== 2'b10) begin bad++; $display("FAIL rmid_resp got=%b exp=10", rsp_valid); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        rsp_ready = 2'b11;
        exp_q.delete();
        inflight = 0;
        repeat (4) begin
            tick();
            total++;
            if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rmid_resp_drop got=%b exp=00", rsp_valid); end
        end
        total++;
        if (obs_q.size() != 0) begin bad++; $display("FAIL rmid_resp_obs got=%0d exp=0", obs_q.size()); end
        load(0, 32'd6, 32'd6, 4'b0000, {32'd12, 1'b0, 1'b0});
        run(10);
        total++;
        if (timed_out) begin bad++; $display("FAIL rmid_timeout got=pending exp=drained"); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            total++;
            if (o !== e) begin bad++; $display("FAIL rmid_sb got=%h exp=%h", o, e); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_missing got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_fixed_prio();
        int grants;
        grants = 0;
        fp_rsp_ready = 2'b11;
        fp_valid = 2'b11;
        repeat (12) begin
            #1;
            if (fp_ready != 2'b00) begin
                grants++;
                total++;
                if (fp_ready !== 2'b01) begin bad++; $display("FAIL fp_grant got=%b exp=01", fp_ready); end
            end
            if (fp_rsp_valid != 2'b00) begin
                total++;
                if (fp_rsp_valid !== 2'b01 || fp_result !== 32'd11) begin
                    bad++; $display("FAIL fp_rsp got=valid %b res %h exp=valid 01 res b", fp_rsp_valid, fp_result);
                end
            end
            @(negedge clk);
        end
        fp_valid = 2'b00;
        total++;
        if (grants < 3) begin bad++; $display("FAIL fp_grants got=%0d exp>=3", grants); end
    endtask

    initial begin
        a = '{32'd0, 32'd0};
        b = '{32'd0, 32'd0};
        f = '{4'd0, 4'd0};
        exp_r = '{34'd0, 34'd0};
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_opcodes();
        test_reset_mid();
        test_fixed_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
